// File: rtl/hazard_unit.sv
// Pipeline hazard controller: RAW interlock / load-use detection, multi-cycle
// EX hold, redirect flush and a saturating stall-cycle counter.
module hazard_unit #(
    parameter int FORWARDING = 0,
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_is_mc,
    input  logic             ex_redirect,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             idex_write_en,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             ex_hold,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JALR      = 7'b1100111;

    // Counter width floored at 1 so MC_LATENCY<=2 still elaborates.
    localparam int CW = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((MC_LATENCY > 1) ? MC_LATENCY - 2 : 0);

    typedef enum logic {IDLE, BUSY} mc_state_t;

    mc_state_t       state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            hold_raw;
    logic            uses_rs1, uses_rs2;
    logic            hit_rs1, hit_rs2, data_stall;

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        unique case (id_opcode)
            OP_ARITH, OP_STORE, OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_ARITH_IMM, OP_LOAD, OP_JALR: uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        if (FORWARDING != 0) begin
            hit_rs1 = (id_rs1 == ex_rd) && ex_valid && ex_reg_write && ex_mem_read;
            hit_rs2 = (id_rs2 == ex_rd) && ex_valid && ex_reg_write && ex_mem_read;
        end else begin
            hit_rs1 = ((id_rs1 == ex_rd) && ex_valid && ex_reg_write) ||
                      ((id_rs1 == mem_rd) && mem_reg_write);
            hit_rs2 = ((id_rs2 == ex_rd) && ex_valid && ex_reg_write) ||
                      ((id_rs2 == mem_rd) && mem_reg_write);
        end
        data_stall = id_valid &&
                     ((uses_rs1 && (id_rs1 != 5'd0) && hit_rs1) ||
                      (uses_rs2 && (id_rs2 != 5'd0) && hit_rs2));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        hold_raw   = 1'b0;
        unique case (state)
            IDLE: begin
                if (ex_valid && ex_is_mc && (MC_LATENCY > 1)) begin
                    hold_raw   = 1'b1;
                    state_next = BUSY;
                    cnt_next   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    hold_raw = 1'b1;
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        idex_write_en = 1'b1;
        idex_bubble   = 1'b0;
        exmem_bubble  = 1'b0;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        ex_hold       = 1'b0;
        if (!reset) begin
            if (hold_raw) begin
                ex_hold       = 1'b1;
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
                idex_write_en = 1'b0;
                exmem_bubble  = 1'b1;
            end else if (ex_redirect) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (data_stall) begin
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
                idex_bubble   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (!pc_write_en && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule
